// File: rtl/game_status_ctrl.sv
// Game state / score / player-blood controller for ENEMY_NUM enemy channels.
// Hit and kill pulses are latched per channel between frames and applied once per frame tick.
module game_status_ctrl #(
  parameter int ENEMY_NUM      = 4,
  parameter int SCORE_W        = 8,
  parameter int BLOOD_W        = 10,
  parameter int FULL_BLOOD     = 100,
  parameter int KILL_PTS       = 1,
  parameter int DMG_PER_HIT    = 5,
  parameter int INVULN_FRAMES  = 30,
  parameter int KILLS_PER_WAVE = 8,
  parameter int WAVE_W         = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 game_frame_clk_rising_edge,
  input  logic                 start,
  input  logic [ENEMY_NUM-1:0] Enemy_Kill,
  input  logic [ENEMY_NUM-1:0] Enemy_Attack_Hit,
  output logic [1:0]           Game_State,
  output logic [SCORE_W-1:0]   Score,
  output logic [BLOOD_W-1:0]   Player_Blood,
  output logic [WAVE_W-1:0]    Wave,
  output logic                 Invuln,
  output logic                 Game_Over
);

  localparam int CNT_W = $clog2(ENEMY_NUM + 1);
  localparam int SUM_W = SCORE_W + 16;
  localparam int DMG_W = BLOOD_W + 5;
  localparam int WK_W  = $clog2(2 * KILLS_PER_WAVE);
  localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((64'd1 << SCORE_W) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [ENEMY_NUM-1:0] r_pend_kill, w_pend_kill_next;
  logic [ENEMY_NUM-1:0] r_pend_hit, w_pend_hit_next;
  logic [SCORE_W-1:0]   r_score, w_score_next;
  logic [BLOOD_W-1:0]   r_blood, w_blood_next;
  logic [WAVE_W-1:0]    r_wave, w_wave_next;
  logic [WK_W-1:0]      r_wave_kills, w_wave_kills_next;
  logic [INV_W-1:0]     r_invuln_cnt, w_invuln_cnt_next;
  logic                 r_invuln;
  logic                 r_game_over;

  logic                 w_tick;
  logic [CNT_W-1:0]     w_kills;
  logic [CNT_W-1:0]     w_hits;
  logic [SUM_W-1:0]     w_score_sum;
  logic [SCORE_W-1:0]   w_score_sat;
  logic [WK_W-1:0]      w_wk;
  logic                 w_wave_adv;
  logic [DMG_W-1:0]     w_dmg;
  logic                 w_dmg_taken;
  logic [BLOOD_W-1:0]   w_blood_hit;
  logic [BLOOD_W-1:0]   w_blood_upd;

  function automatic logic [CNT_W-1:0] popcnt(input logic [ENEMY_NUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ENEMY_NUM; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Frame-tick arithmetic always works on the pending values latched during the previous frame.
  assign w_tick      = (r_state == ST_PLAY) && game_frame_clk_rising_edge;
  assign w_kills     = popcnt(r_pend_kill);
  assign w_hits      = popcnt(r_pend_hit);
  assign w_score_sum = SUM_W'(r_score) + SUM_W'(w_kills) * SUM_W'(KILL_PTS);
  assign w_score_sat = (w_score_sum > SCORE_MAX) ? '1 : w_score_sum[SCORE_W-1:0];
  assign w_wk        = r_wave_kills + WK_W'(w_kills);
  assign w_wave_adv  = (w_wk >= WK_W'(KILLS_PER_WAVE));
  assign w_dmg       = DMG_W'(w_hits) * DMG_W'(DMG_PER_HIT);
  assign w_dmg_taken = (r_invuln_cnt == '0) && (w_dmg != '0);
  assign w_blood_hit = (DMG_W'(r_blood) > w_dmg) ? (r_blood - w_dmg[BLOOD_W-1:0]) : '0;
  assign w_blood_upd = w_dmg_taken ? w_blood_hit : r_blood;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: each combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_PLAY;
      ST_PLAY: if (w_tick && (w_blood_upd == '0)) w_state_next = ST_OVER;
      ST_OVER: if (start) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pend_kill_next  = '0;
    w_pend_hit_next   = '0;
    w_score_next      = r_score;
    w_blood_next      = r_blood;
    w_wave_next       = r_wave;
    w_wave_kills_next = r_wave_kills;
    w_invuln_cnt_next = r_invuln_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_score_next      = '0;
          w_blood_next      = BLOOD_W'(FULL_BLOOD);
          w_wave_next       = '0;
          w_wave_kills_next = '0;
          w_invuln_cnt_next = '0;
        end
      end
      ST_PLAY: begin
        // A pulse arriving on the tick cycle is kept for the following frame.
        w_pend_kill_next = (r_pend_kill & ~{ENEMY_NUM{game_frame_clk_rising_edge}}) | Enemy_Kill;
        w_pend_hit_next  = (r_pend_hit  & ~{ENEMY_NUM{game_frame_clk_rising_edge}}) | Enemy_Attack_Hit;
        if (w_tick) begin
          w_score_next = w_score_sat;
          if (w_wave_adv) begin
            w_wave_next       = (r_wave == '1) ? r_wave : r_wave + 1'b1;
            w_wave_kills_next = w_wk - WK_W'(KILLS_PER_WAVE);
          end else begin
            w_wave_kills_next = w_wk;
          end
          if (r_invuln_cnt != '0) begin
            w_invuln_cnt_next = r_invuln_cnt - 1'b1;
          end else if (w_dmg_taken) begin
            w_blood_next      = w_blood_hit;
            w_invuln_cnt_next = INV_W'(INVULN_FRAMES);
          end
        end
      end
      ST_OVER: w_invuln_cnt_next = '0;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend_kill  <= '0;
      r_pend_hit   <= '0;
      r_score      <= '0;
      r_blood      <= BLOOD_W'(FULL_BLOOD);
      r_wave       <= '0;
      r_wave_kills <= '0;
      r_invuln_cnt <= '0;
      r_invuln     <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_pend_kill  <= w_pend_kill_next;
      r_pend_hit   <= w_pend_hit_next;
      r_score      <= w_score_next;
      r_blood      <= w_blood_next;
      r_wave       <= w_wave_next;
      r_wave_kills <= w_wave_kills_next;
      r_invuln_cnt <= w_invuln_cnt_next;
      r_invuln     <= (w_invuln_cnt_next != '0);
      r_game_over  <= (r_state == ST_PLAY) && (w_state_next == ST_OVER);
    end
  end

  assign Game_State   = r_state;
  assign Score        = r_score;
  assign Player_Blood = r_blood;
  assign Wave         = r_wave;
  assign Invuln       = r_invuln;
  assign Game_Over    = r_game_over;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Self-checking bench for game_status_ctrl: directed vector table, multi-cycle corner sequences,
// then random stimulus against a frame-level reference model.
module tb_game_status_ctrl;

  localparam int EN = 4, SW = 8, BW = 10, FB = 100, KP = 1, DPH = 5;
  localparam int INV = 30, KPW = 8, WW = 4;
  localparam int SCORE_MAX = (1 << SW) - 1;
  localparam int WAVE_MAX  = (1 << WW) - 1;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic [EN-1:0] kill = '0;
  logic [EN-1:0] hit = '0;
  logic [1:0]    Game_State;
  logic [SW-1:0] Score;
  logic [BW-1:0] Player_Blood;
  logic [WW-1:0] Wave;
  logic          Invuln;
  logic          Game_Over;

  game_status_ctrl #(
    .ENEMY_NUM(EN), .SCORE_W(SW), .BLOOD_W(BW), .FULL_BLOOD(FB), .KILL_PTS(KP),
    .DMG_PER_HIT(DPH), .INVULN_FRAMES(INV), .KILLS_PER_WAVE(KPW), .WAVE_W(WW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .game_frame_clk_rising_edge(tick), .start(start),
    .Enemy_Kill(kill), .Enemy_Attack_Hit(hit), .Game_State(Game_State), .Score(Score),
    .Player_Blood(Player_Blood), .Wave(Wave), .Invuln(Invuln), .Game_Over(Game_Over)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: score and wave derive from the total kills credited since the game began.
  int            m_state, m_total_kills, m_blood, m_inv, m_go;
  logic [EN-1:0] m_pk, m_ph;

  typedef struct {
    bit            t;
    bit            s;
    logic [EN-1:0] k;
    logic [EN-1:0] h;
    int            e_state;
    int            e_score;
    int            e_blood;
    int            e_wave;
    int            e_inv;
    int            e_go;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_total_kills = 0; m_blood = FB; m_inv = 0; m_go = 0; m_pk = '0; m_ph = '0;
  endtask

  task automatic model_clock(input bit t, input bit s, input logic [EN-1:0] k, input logic [EN-1:0] h);
    int d;
    m_go = 0;
    case (m_state)
      0: begin
        m_pk = '0; m_ph = '0;
        if (s) begin
          m_state = 1; m_total_kills = 0; m_blood = FB; m_inv = 0;
        end
      end
      1: begin
        if (t) begin
          m_total_kills += $countones(m_pk);
          d = $countones(m_ph) * DPH;
          if (m_inv > 0) m_inv--;
          else if (d > 0) begin
            m_blood = (m_blood > d) ? m_blood - d : 0;
            m_inv = INV;
          end
          if (m_blood == 0) begin
            m_state = 2; m_go = 1;
          end
          m_pk = k; m_ph = h;
        end else begin
          m_pk |= k; m_ph |= h;
        end
      end
      default: begin
        m_pk = '0; m_ph = '0; m_inv = 0;
        if (s) m_state = 0;
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, int'(Game_State), m_state);
    check({tag, ".score"}, int'(Score), min2(m_total_kills * KP, SCORE_MAX));
    check({tag, ".blood"}, int'(Player_Blood), m_blood);
    check({tag, ".wave"}, int'(Wave), min2(m_total_kills / KPW, WAVE_MAX));
    check({tag, ".invuln"}, int'(Invuln), (m_inv != 0) ? 1 : 0);
    check({tag, ".game_over"}, int'(Game_Over), m_go);
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit t, input bit s, input logic [EN-1:0] k, input logic [EN-1:0] h,
                      input string tag);
    tick = t; start = s; kill = k; hit = h;
    model_clock(t, s, k, h);
    @(posedge Clk);
    #1;
    tick = 1'b0; start = 1'b0; kill = '0; hit = '0;
    check_model(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    Reset_n = 1'b0;
    #1;
    check({tag, ".rst_state"}, int'(Game_State), 0);
    check({tag, ".rst_score"}, int'(Score), 0);
    check({tag, ".rst_blood"}, int'(Player_Blood), FB);
    check({tag, ".rst_wave"}, int'(Wave), 0);
    check({tag, ".rst_invuln"}, int'(Invuln), 0);
    check({tag, ".rst_game_over"}, int'(Game_Over), 0);
    model_reset();
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1,  0, 100, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1,  0, 100, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1,  0, 100, 0, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1,  0, 100, 0, 0, 0};
    tbl[4] = '{1'b0, 1'b0, 4'b1011, 4'b0000, 1,  0, 100, 0, 0, 0};
    tbl[5] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1,  3, 100, 0, 0, 0};
    tbl[6] = '{1'b1, 1'b0, 4'b1011, 4'b0000, 1,  3, 100, 0, 0, 0};
    tbl[7] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1,  6, 100, 0, 0, 0};
    tbl[8] = '{1'b0, 1'b0, 4'b0000, 4'b0011, 1,  6, 100, 0, 0, 0};
    tbl[9] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1,  6,  90, 0, 1, 0};

    model_reset();
    #12;
    check("reset.state", int'(Game_State), 0);
    check("reset.blood", int'(Player_Blood), FB);
    check("reset.score", int'(Score), 0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed table: start, idle frames, kill latching and tick-cycle pulse carry-over, first hit.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].t, tbl[i].s, tbl[i].k, tbl[i].h, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.exp_state", i), int'(Game_State), tbl[i].e_state);
      check($sformatf("tbl%0d.exp_score", i), int'(Score), tbl[i].e_score);
      check($sformatf("tbl%0d.exp_blood", i), int'(Player_Blood), tbl[i].e_blood);
      check($sformatf("tbl%0d.exp_wave", i), int'(Wave), tbl[i].e_wave);
      check($sformatf("tbl%0d.exp_invuln", i), int'(Invuln), tbl[i].e_inv);
      check($sformatf("tbl%0d.exp_go", i), int'(Game_Over), tbl[i].e_go);
    end

    // Invulnerability window: hits on the next 30 ticks are discarded, the 31st lands.
    for (int i = 0; i < INV; i++) begin
      step(1'b0, 1'b0, '0, 4'b0001, "inv_hit");
      step(1'b1, 1'b0, '0, '0, "inv_tick");
      check("inv_window_blood", int'(Player_Blood), 90);
    end
    check("inv_expired", int'(Invuln), 0);
    step(1'b0, 1'b0, '0, 4'b0001, "inv31_hit");
    step(1'b1, 1'b0, '0, '0, "inv31_tick");
    check("inv31_blood", int'(Player_Blood), 85);
    check("inv31_invuln", int'(Invuln), 1);

    // Drain blood to 5 with 4-hit frames, then a final 20-point frame ends the game.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < INV; i++) step(1'b1, 1'b0, '0, '0, "drain_idle");
      step(1'b0, 1'b0, '0, 4'b1111, "drain_hit");
      step(1'b1, 1'b0, '0, '0, "drain_tick");
      if (r == 3) check("drain_blood5", int'(Player_Blood), 5);
    end
    check("over_blood", int'(Player_Blood), 0);
    check("over_state", int'(Game_State), 2);
    check("over_pulse", int'(Game_Over), 1);
    step(1'b1, 1'b1, 4'b1111, 4'b1111, "over_hold");
    check("over_pulse_drop", int'(Game_Over), 0);
    check("over_state_hold", int'(Game_State), 0);
    step(1'b0, 1'b1, '0, '0, "restart");
    check("restart_state", int'(Game_State), 1);
    check("restart_blood", int'(Player_Blood), FB);
    check("restart_score", int'(Score), 0);

    // Wave advance, wave_kills carry, score and wave saturation.
    step(1'b0, 1'b0, 4'b1111, '0, "w_k1"); step(1'b1, 1'b0, '0, '0, "w_t1");
    step(1'b0, 1'b0, 4'b1111, '0, "w_k2"); step(1'b1, 1'b0, '0, '0, "w_t2");
    step(1'b0, 1'b0, 4'b0001, '0, "w_k3"); step(1'b1, 1'b0, '0, '0, "w_t3");
    check("wave1", int'(Wave), 1);
    check("score9", int'(Score), 9);
    step(1'b0, 1'b0, 4'b1111, '0, "w_k4"); step(1'b1, 1'b0, '0, '0, "w_t4");
    step(1'b0, 1'b0, 4'b0111, '0, "w_k5"); step(1'b1, 1'b0, '0, '0, "w_t5");
    check("wave2_carry", int'(Wave), 2);
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b0, 4'b1111, '0, "sat_k");
      step(1'b1, 1'b0, '0, '0, "sat_t");
    end
    check("score_sat", int'(Score), SCORE_MAX);
    check("wave_sat", int'(Wave), WAVE_MAX);

    // Reset mid-frame with pending events and a nonzero score.
    step(1'b0, 1'b0, 4'b1111, 4'b1111, "pre_rst");
    async_reset("midplay");
    check_model("post_rst");

    // Random stimulus against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic [EN-1:0] rk, rh;
      rk = EN'($urandom & $urandom);
      rh = ($urandom_range(0, 3) == 0) ? EN'($urandom) : '0;
      if ($urandom_range(0, 999) == 0) async_reset("rnd");
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, rk, rh, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
